// File: rtl/aes_round_seq.sv
// aes_round_seq
// Iterative round sequencer for an AES-128/192/256 encryption datapath.
// It takes one block per input handshake and walks it through INIT (initial
// AddRoundKey), the middle rounds, and a FINAL round that bypasses the
// mix-columns stage. It then holds the result in DONE until downstream takes it.
//
// Parameters:
//   NUM_ROUNDS      total cipher rounds (10, 12 or 14)
//
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   in_valid_i      plaintext and key present on the datapath inputs
//   in_ready_o      sequencer can accept a block
//   out_valid_o     ciphertext in the datapath state register is valid
//   out_ready_i     downstream consumes the ciphertext
//   round_idx_o     current round number, 0..NUM_ROUNDS
//   rcon_o          round constant for the current key-schedule step
//   state_ld_o      load the datapath state register
//   key_ld_o        load the round-key register
//   first_round_o   state mux selects input XOR key
//   mixcol_bypass_o skip the mix-columns stage (final round)
//   busy_o          block in flight
//
// Optional feature (macro AES_SEQ_BLKCNT_EN):
//   cnt_clr_i       synchronous clear of the block counter
//   blk_count_o     count of completed output handshakes (wraps)

module aes_round_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] round_idx_o,
  output logic [7:0] rcon_o,
  output logic       state_ld_o,
  output logic       key_ld_o,
  output logic       first_round_o,
  output logic       mixcol_bypass_o,
  output logic       busy_o
`ifdef AES_SEQ_BLKCNT_EN
  ,
  input  logic       cnt_clr_i,
  output logic [15:0] blk_count_o
`endif
);

  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : gen_bad_rounds
    $error("aes_round_seq: NUM_ROUNDS must be 10, 12 or 14");
  end

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic       active_q, active_d;
  logic       first_q, first_d;
  logic       bypass_q, bypass_d;
  logic       valid_q, valid_d;
  logic       ready_q;

  // GF(2^8) doubling used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // The ready flop holds in_ready low through reset and for the first edge after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  assign in_ready_o = ready_q && (state_q == IDLE);

  // Next-state logic. round_d and rcon_d are the values for the state being
  // entered, so the registered index and constant stay aligned with state_q.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      IDLE: begin
        round_d = 4'd0;
        rcon_d  = 8'h00;
        if (in_valid_i && in_ready_o) state_d = INIT;
      end
      INIT: begin
        state_d = ROUND;
        round_d = 4'd1;
        rcon_d  = 8'h01;
      end
      ROUND: begin
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        if (round_q + 4'd1 == LastRound) state_d = FINAL;
      end
      FINAL: begin
        state_d = DONE;
        rcon_d  = 8'h00;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
        rcon_d  = 8'h00;
      end
    endcase
  end

  // Decoding the outputs from state_d lets them come straight from flops
  // while still lining up with the state they describe.
  always_comb begin
    active_d = (state_d == INIT) || (state_d == ROUND) || (state_d == FINAL);
    first_d  = (state_d == INIT);
    bypass_d = (state_d == FINAL);
    valid_d  = (state_d == DONE);
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      round_q  <= 4'd0;
      rcon_q   <= 8'h00;
      active_q <= 1'b0;
      first_q  <= 1'b0;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      rcon_q   <= rcon_d;
      active_q <= active_d;
      first_q  <= first_d;
      bypass_q <= bypass_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid_o     = valid_q;
  assign round_idx_o     = round_q;
  assign rcon_o          = rcon_q;
  assign state_ld_o      = active_q;
  assign key_ld_o        = active_q;
  assign busy_o          = active_q;
  assign first_round_o   = first_q;
  assign mixcol_bypass_o = bypass_q;

`ifdef AES_SEQ_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  // The clear takes priority over a coincident output handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                blk_cnt_q <= 16'd0;
    else if (cnt_clr_i)                         blk_cnt_q <= 16'd0;
    else if ((state_q == DONE) && out_ready_i)  blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_count_o = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
module tb_aes_round_seq;

   localparam int NR      = 10;
   localparam int Latency = NR + 2;
   localparam int Period  = NR + 3;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       inValid = 1'b0;
   logic       outReady = 1'b0;
   logic       inReady;
   logic       outValid;
   logic [3:0] roundIdx;
   logic [7:0] rcon;
   logic       stateLd;
   logic       keyLd;
   logic       firstRound;
   logic       mixcolBypass;
   logic       busy;
`ifdef AES_SEQ_BLKCNT_EN
   logic        cntClr = 1'b0;
   logic [15:0] blkCount;
`endif

   int numChecks = 0;
   int numErrors = 0;

   // Monitor / scoreboard state, written only by the monitor process.
   bit monEn = 1'b0;
   bit contMode = 1'b0;
   int phase = 0;
   int cycleCnt = 0;
   int hsCount = 0;
   int lastAccept = 0;
   bit lastAcceptValid = 1'b0;
   bit prevOutValid = 1'b0;
   int expQ[$];
   int expCnt = 0;

   logic [7:0] rconTab [0:14] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

   aes_round_seq #(.NUM_ROUNDS(NR)) dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .in_valid_i      (inValid),
      .in_ready_o      (inReady),
      .out_valid_o     (outValid),
      .out_ready_i     (outReady),
      .round_idx_o     (roundIdx),
      .rcon_o          (rcon),
      .state_ld_o      (stateLd),
      .key_ld_o        (keyLd),
      .first_round_o   (firstRound),
      .mixcol_bypass_o (mixcolBypass),
      .busy_o          (busy)
`ifdef AES_SEQ_BLKCNT_EN
      ,
      .cnt_clr_i       (cntClr),
      .blk_count_o     (blkCount)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single point for every comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drives the block inputs just after a rising edge.
   task automatic applyStimulus(input bit valid, input bit ready);
      @(posedge clk);
      #1;
      inValid  = valid;
      outReady = ready;
   endtask

   // One-cycle in_valid pulse; caller guarantees the sequencer is idle.
   task automatic sendBlock(input bit ready);
      applyStimulus(1'b1, ready);
      applyStimulus(1'b0, ready);
   endtask

   // Bounded wait for out_valid; an expired budget shows up as a failed check.
   task automatic waitOutValid(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (outValid) break;
      end
      checkOutput(tag, outValid, 1'b1);
   endtask

   // Every output is zero while reset is asserted.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, inReady, 1'b0);
      checkOutput({tag, "_out_valid"}, outValid, 1'b0);
      checkOutput({tag, "_round_idx"}, roundIdx, 4'd0);
      checkOutput({tag, "_rcon"}, rcon, 8'h00);
      checkOutput({tag, "_strobes"}, {stateLd, keyLd, firstRound, mixcolBypass, busy}, 5'b0);
`ifdef AES_SEQ_BLKCNT_EN
      checkOutput({tag, "_blk_count"}, blkCount, 16'd0);
`endif
   endtask

   // Monitor: phase 0 is idle, 1..NR+1 are INIT/rounds/FINAL, NR+2 is DONE.
   // Expected outputs for each phase come from the behaviour description
   // and the constant round-constant table above.
   always @(negedge clk) begin
      if (!monEn) begin
         phase = 0;
         expQ.delete();
         prevOutValid = 1'b0;
         lastAcceptValid = 1'b0;
         expCnt = 0;
      end else begin
         cycleCnt++;
         if (phase == 0) begin
            checkOutput("idle_in_ready", inReady, 1'b1);
            checkOutput("idle_out_valid", outValid, 1'b0);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_strobes", {stateLd, keyLd, firstRound, mixcolBypass}, 4'b0);
            checkOutput("idle_rcon", rcon, 8'h00);
         end else if (phase <= NR + 1) begin
            checkOutput("round_idx", roundIdx, phase - 1);
            checkOutput("rcon", rcon, rconTab[phase - 1]);
            checkOutput("first_round", firstRound, phase == 1);
            checkOutput("mixcol_bypass", mixcolBypass, phase == NR + 1);
            checkOutput("busy_strobes", {stateLd, keyLd, busy}, 3'b111);
            checkOutput("busy_in_ready", inReady, 1'b0);
            checkOutput("busy_out_valid", outValid, 1'b0);
         end else begin
            checkOutput("done_out_valid", outValid, 1'b1);
            checkOutput("done_round_idx", roundIdx, NR);
            checkOutput("done_rcon", rcon, 8'h00);
            checkOutput("done_strobes", {stateLd, keyLd, firstRound, mixcolBypass, busy}, 5'b0);
            checkOutput("done_in_ready", inReady, 1'b0);
         end

         if (outValid && !prevOutValid) begin
            if (expQ.size() == 0) checkOutput("spurious_out_valid", outValid, 1'b0);
            else checkOutput("latency", cycleCnt, expQ.pop_front());
         end
         prevOutValid = outValid;

`ifdef AES_SEQ_BLKCNT_EN
         checkOutput("blk_count", blkCount, expCnt);
         if (cntClr) expCnt = 0;
         else if (phase == NR + 2 && outReady) expCnt = (expCnt + 1) % 65536;
`endif

         if (phase == 0) begin
            if (inValid) begin
               expQ.push_back(cycleCnt + Latency);
               if (contMode && lastAcceptValid) checkOutput("accept_gap", cycleCnt - lastAccept, Period);
               lastAccept = cycleCnt;
               lastAcceptValid = contMode;
               phase = 1;
            end
         end else if (phase <= NR + 1) begin
            phase++;
         end else if (outReady) begin
            hsCount++;
            phase = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting aes_round_seq bench, NUM_ROUNDS=%0d", NR);

      // Power-on reset and the one-edge delay on in_ready.
      #12;
      checkResetOutputs("reset");
      @(negedge clk);
      #1;
      rstN = 1'b1;
      #1;
      checkOutput("in_ready_before_edge", inReady, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("in_ready_after_edge", inReady, 1'b1);
      monEn = 1'b1;

      // Single block with downstream always ready.
      sendBlock(1'b1);
      repeat (16) @(posedge clk);
      #1;
      checkOutput("hs_count_single", hsCount, 1);

      // Backpressure: result held in DONE until out_ready rises.
      sendBlock(1'b0);
      waitOutValid("bp_out_valid_seen", 30);
      repeat (5) @(negedge clk);
      #1;
      checkOutput("bp_out_valid_held", outValid, 1'b1);
      checkOutput("bp_in_ready_low", inReady, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_in_ready_back", inReady, 1'b1);
      checkOutput("hs_count_bp", hsCount, 2);

      // in_valid held high: back-to-back blocks, extra requests ignored.
      contMode = 1'b1;
      applyStimulus(1'b1, 1'b1);
      repeat (3 * Period + 1) @(posedge clk);
      #1;
      inValid = 1'b0;
      contMode = 1'b0;
      repeat (Period + 4) @(posedge clk);
      #1;
      checkOutput("hs_count_cont", hsCount, 6);

      // Reset pulsed in the middle of a block discards it.
      sendBlock(1'b1);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (roundIdx == 4'd5) break;
      end
      checkOutput("reached_round5", roundIdx, 4'd5);
      monEn = 1'b0;
      #1;
      rstN = 1'b0;
      #1;
      checkResetOutputs("midreset");
      repeat (2) @(negedge clk);
      #1;
      rstN = 1'b1;
      #1;
      checkOutput("midreset_in_ready_before_edge", inReady, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("midreset_in_ready_after_edge", inReady, 1'b1);
      monEn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("hs_count_after_reset", hsCount, 6);

      // Three more blocks, then a counter clear coincident with a handshake.
      for (int b = 0; b < 3; b++) begin
         sendBlock(1'b1);
         repeat (Period + 2) @(posedge clk);
      end
      #1;
      checkOutput("hs_count_three", hsCount, 9);
`ifdef AES_SEQ_BLKCNT_EN
      checkOutput("blk_count_three", blkCount, 16'd3);
`endif
      sendBlock(1'b0);
      waitOutValid("blk4_out_valid_seen", 30);
      @(posedge clk);
      #1;
      outReady = 1'b1;
`ifdef AES_SEQ_BLKCNT_EN
      cntClr = 1'b1;
`endif
      @(posedge clk);
      #1;
`ifdef AES_SEQ_BLKCNT_EN
      cntClr = 1'b0;
      checkOutput("blk_count_clear_wins", blkCount, 16'd0);
`endif
      checkOutput("blk4_out_valid_dropped", outValid, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("hs_count_final", hsCount, 10);

      monEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
